// File: rtl/pcie_trn_tx_fifo_if.sv
// User-side beat stream and TRN transmit pins of the TX framer.
// slave is the framer's view; master is the user/endpoint model's view.
interface pcie_trn_tx_fifo_if #(
  parameter int DW = 64
);
  localparam int RW = (DW == 128) ? 2 : 1;

  logic              s_valid;
  logic              s_ready;
  logic              s_sof;
  logic              s_eof;
  logic [RW-1:0]     s_dw;
  logic [DW-1:0]     s_data;

  logic              trn_lnk_up_n;
  logic [DW-1:0]     trn_td;
  logic [DW/8-1:0]   trn_trem_n;
  logic              trn_tsof_n;
  logic              trn_teof_n;
  logic              trn_tsrc_rdy_n;
  logic              trn_tsrc_dsc_n;
  logic              trn_tdst_rdy_n;
  logic              trn_tdst_dsc_n;
  logic [3:0]        trn_tbuf_av;

  modport slave (
    input  s_valid, s_sof, s_eof, s_dw, s_data,
    input  trn_lnk_up_n, trn_tdst_rdy_n, trn_tdst_dsc_n, trn_tbuf_av,
    output s_ready,
    output trn_td, trn_trem_n, trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n, trn_tsrc_dsc_n
  );

  modport master (
    output s_valid, s_sof, s_eof, s_dw, s_data,
    output trn_lnk_up_n, trn_tdst_rdy_n, trn_tdst_dsc_n, trn_tbuf_av,
    input  s_ready,
    input  trn_td, trn_trem_n, trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n, trn_tsrc_dsc_n
  );
endinterface

// File: rtl/pcie_trn_tx_fifo.sv
// TRN transmit framer: FWFT beat FIFO, packet-start gating on link/tbuf_av,
// remainder mapping onto trn_trem_n, and flushing of discontinued packets.
module pcie_trn_tx_fifo #(
  parameter int DW       = 64,
  parameter int DEPTH    = 16,
  parameter int MIN_TBUF = 1
) (
  input  logic                       trn_clk,
  input  logic                       trn_reset,
  pcie_trn_tx_fifo_if.slave          bus,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic [15:0]                drop_count
);

  localparam int RW  = (DW == 128) ? 2 : 1;
  localparam int NDW = DW / 32;
  localparam int RMW = DW / 8;
  localparam int AW  = $clog2(DEPTH);
  localparam int LW  = AW + 1;
  localparam int EW  = 2 + RW + DW;
  localparam logic [3:0] MIN_TBUF_L = 4'(MIN_TBUF);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_DRAIN
  } state_t;

  state_t           r_state;
  logic [EW-1:0]    r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic [15:0]      r_drop;

  logic             w_full;
  logic             w_head_valid;
  logic [EW-1:0]    w_head;
  logic             w_head_sof;
  logic             w_head_eof;
  logic [RW-1:0]    w_head_dw;
  logic [DW-1:0]    w_head_data;
  logic             w_push;
  logic             w_pop;
  logic             w_drop;
  logic             w_abort;
  logic             w_start;
  logic             w_tsrc_rdy;

  function automatic logic [RMW-1:0] f_trem(input logic eof, input logic [RW-1:0] dw);
    logic [RMW-1:0] m;
    m = '1;
    for (int i = 0; i < NDW; i++) begin
      if (!eof || (i <= int'(dw))) m[RMW-1-4*i -: 4] = 4'h0;
    end
    return m;
  endfunction

  function automatic logic [15:0] f_sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign w_full       = (r_level == LW'(DEPTH));
  assign w_head_valid = (r_level != '0);
  assign w_head       = r_mem[r_rd_ptr];
  assign w_head_sof   = w_head[EW-1];
  assign w_head_eof   = w_head[EW-2];
  assign w_head_dw    = w_head[DW +: RW];
  assign w_head_data  = w_head[DW-1:0];

  assign bus.s_ready  = !w_full && !trn_reset;
  assign w_push       = bus.s_valid && bus.s_ready;

  // Packet start is gated only here; mid-packet tbuf_av changes are ignored.
  assign w_start = w_head_valid && w_head_sof && !bus.trn_lnk_up_n &&
                   (bus.trn_tbuf_av >= MIN_TBUF_L);
  assign w_abort = !bus.trn_tdst_dsc_n || bus.trn_lnk_up_n;

  always_comb begin
    w_pop  = 1'b0;
    w_drop = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_head_valid && !w_head_sof) begin
          w_pop  = 1'b1;
          w_drop = 1'b1;
        end
      end
      S_SEND: begin
        // A discontinue takes priority over a beat that would transfer now.
        if (w_abort) begin
          w_drop = 1'b1;
        end else if (w_head_valid && !bus.trn_tdst_rdy_n) begin
          w_pop = 1'b1;
        end
      end
      S_DRAIN: begin
        w_pop = w_head_valid;
      end
      default: begin
        w_pop  = 1'b0;
        w_drop = 1'b0;
      end
    endcase
  end

  always_ff @(posedge trn_clk or posedge trn_reset) begin
    if (trn_reset) begin
      r_state  <= S_IDLE;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_drop   <= '0;
    end else begin
      case (r_state)
        S_IDLE:  if (w_start) r_state <= S_SEND;
        S_SEND: begin
          if (w_abort)                  r_state <= S_DRAIN;
          else if (w_pop && w_head_eof) r_state <= S_IDLE;
        end
        S_DRAIN: if (w_pop && w_head_eof) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_level <= r_level + LW'(w_push) - LW'(w_pop);
      if (w_drop) r_drop <= f_sat_inc(r_drop);
    end
  end

  always_ff @(posedge trn_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {bus.s_sof, bus.s_eof, bus.s_dw, bus.s_data};
  end

  assign w_tsrc_rdy         = (r_state == S_SEND) && w_head_valid;
  assign bus.trn_tsrc_rdy_n = !w_tsrc_rdy;
  assign bus.trn_tsof_n     = !(w_tsrc_rdy && w_head_sof);
  assign bus.trn_teof_n     = !(w_tsrc_rdy && w_head_eof);
  assign bus.trn_tsrc_dsc_n = 1'b1;
  assign bus.trn_td         = w_tsrc_rdy ? w_head_data : '0;
  assign bus.trn_trem_n     = w_tsrc_rdy ? f_trem(w_head_eof, w_head_dw) : '1;

  assign fifo_level = r_level;
  assign drop_count = r_drop;

endmodule

// File: tb/tb_pcie_trn_tx_fifo.sv
// Directed bench for the TRN TX framer: one 64-bit and one 128-bit instance.
module tb_pcie_trn_tx_fifo;

  logic        clk;
  logic        rst64;
  logic        rst128;
  logic [4:0]  lvl64;
  logic [4:0]  lvl128;
  logic [15:0] drop64;
  logic [15:0] drop128;
  int          checks;
  int          errors;

  pcie_trn_tx_fifo_if #(.DW(64))  b64 ();
  pcie_trn_tx_fifo_if #(.DW(128)) b128 ();

  pcie_trn_tx_fifo #(.DW(64), .DEPTH(16), .MIN_TBUF(1)) u64 (
    .trn_clk    (clk),
    .trn_reset  (rst64),
    .bus        (b64),
    .fifo_level (lvl64),
    .drop_count (drop64)
  );

  pcie_trn_tx_fifo #(.DW(128), .DEPTH(16), .MIN_TBUF(1)) u128 (
    .trn_clk    (clk),
    .trn_reset  (rst128),
    .bus        (b128),
    .fifo_level (lvl128),
    .drop_count (drop128)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put64(input logic sof, input logic eof, input logic dw, input logic [63:0] d);
    b64.s_valid = 1'b1;
    b64.s_sof   = sof;
    b64.s_eof   = eof;
    b64.s_dw    = dw;
    b64.s_data  = d;
    step();
  endtask

  task automatic put128(input logic sof, input logic eof, input logic [1:0] dw, input logic [127:0] d);
    b128.s_valid = 1'b1;
    b128.s_sof   = sof;
    b128.s_eof   = eof;
    b128.s_dw    = dw;
    b128.s_data  = d;
    step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clk    = 1'b0;
    rst64  = 1'b0;
    rst128 = 1'b0;
    b64.s_valid = 0;  b64.s_sof = 0;  b64.s_eof = 0;  b64.s_dw = '0;  b64.s_data = '0;
    b64.trn_lnk_up_n = 0;  b64.trn_tdst_rdy_n = 0;  b64.trn_tdst_dsc_n = 1;  b64.trn_tbuf_av = 4'd4;
    b128.s_valid = 0; b128.s_sof = 0; b128.s_eof = 0; b128.s_dw = '0; b128.s_data = '0;
    b128.trn_lnk_up_n = 0; b128.trn_tdst_rdy_n = 0; b128.trn_tdst_dsc_n = 1; b128.trn_tbuf_av = 4'd4;

    #1 rst64 = 1'b1; rst128 = 1'b1;
    #1;
    chk("rst_s_ready",   b64.s_ready, 0);
    chk("rst_tsrc_rdy",  b64.trn_tsrc_rdy_n, 1);
    chk("rst_tsof",      b64.trn_tsof_n, 1);
    chk("rst_teof",      b64.trn_teof_n, 1);
    chk("rst_tsrc_dsc",  b64.trn_tsrc_dsc_n, 1);
    chk("rst_td",        b64.trn_td, 0);
    chk("rst_trem",      b64.trn_trem_n, 8'hFF);
    chk("rst_level",     lvl64, 0);
    chk("rst_drop",      drop64, 0);
    step();
    rst64 = 1'b0; rst128 = 1'b0;
    #1;
    chk("post_rst_s_ready", b64.s_ready, 1);

    // 3-beat packet, eof dw=0
    put64(1, 0, 1, 64'hA000_0000_0000_0000);
    chk("p1_lvl_e1",  lvl64, 1);
    chk("p1_idle_e1", b64.trn_tsrc_rdy_n, 1);
    put64(0, 0, 1, 64'hA000_0000_0000_0001);
    chk("p1_b0_rdy",  b64.trn_tsrc_rdy_n, 0);
    chk("p1_b0_sof",  b64.trn_tsof_n, 0);
    chk("p1_b0_eof",  b64.trn_teof_n, 1);
    chk("p1_b0_td",   b64.trn_td, 64'hA000_0000_0000_0000);
    chk("p1_b0_trem", b64.trn_trem_n, 8'h00);
    put64(0, 1, 0, 64'hA000_0000_0000_0002);
    b64.s_valid = 0;
    chk("p1_b1_rdy",  b64.trn_tsrc_rdy_n, 0);
    chk("p1_b1_sof",  b64.trn_tsof_n, 1);
    chk("p1_b1_td",   b64.trn_td, 64'hA000_0000_0000_0001);
    chk("p1_b1_trem", b64.trn_trem_n, 8'h00);
    step();
    chk("p1_b2_rdy",  b64.trn_tsrc_rdy_n, 0);
    chk("p1_b2_eof",  b64.trn_teof_n, 0);
    chk("p1_b2_sof",  b64.trn_tsof_n, 1);
    chk("p1_b2_td",   b64.trn_td, 64'hA000_0000_0000_0002);
    chk("p1_b2_trem", b64.trn_trem_n, 8'h0F);
    step();
    chk("p1_end_rdy",  b64.trn_tsrc_rdy_n, 1);
    chk("p1_end_td",   b64.trn_td, 0);
    chk("p1_end_trem", b64.trn_trem_n, 8'hFF);
    chk("p1_end_lvl",  lvl64, 0);

    // tbuf_av gating at packet start
    b64.trn_tbuf_av = 4'd0;
    put64(1, 1, 1, 64'hB0B0_0000_0000_0001);
    b64.s_valid = 0;
    step();
    chk("tbuf0_rdy_a", b64.trn_tsrc_rdy_n, 1);
    step();
    chk("tbuf0_rdy_b", b64.trn_tsrc_rdy_n, 1);
    chk("tbuf0_lvl",   lvl64, 1);
    b64.trn_tbuf_av = 4'd1;
    step();
    chk("tbuf1_rdy",  b64.trn_tsrc_rdy_n, 0);
    chk("tbuf1_sof",  b64.trn_tsof_n, 0);
    chk("tbuf1_eof",  b64.trn_teof_n, 0);
    chk("tbuf1_td",   b64.trn_td, 64'hB0B0_0000_0000_0001);
    chk("tbuf1_trem", b64.trn_trem_n, 8'h00);
    step();
    chk("tbuf1_done", b64.trn_tsrc_rdy_n, 1);
    b64.trn_tbuf_av = 4'd4;

    // discontinue on beat 1 of 4, followed by an intact 2-beat packet
    b64.trn_tdst_rdy_n = 1;
    put64(1, 0, 1, 64'hAA00_0000_0000_0000);
    put64(0, 0, 1, 64'hAA00_0000_0000_0001);
    put64(0, 0, 1, 64'hAA00_0000_0000_0002);
    put64(0, 1, 1, 64'hAA00_0000_0000_0003);
    put64(1, 0, 1, 64'hBB00_0000_0000_0000);
    put64(0, 1, 0, 64'hBB00_0000_0000_0001);
    b64.s_valid = 0;
    chk("dsc_lvl6",  lvl64, 6);
    chk("dsc_hold",  b64.trn_td, 64'hAA00_0000_0000_0000);
    b64.trn_tdst_rdy_n = 0;
    step();
    chk("dsc_b1_td", b64.trn_td, 64'hAA00_0000_0000_0001);
    b64.trn_tdst_dsc_n = 0;
    step();
    b64.trn_tdst_dsc_n = 1;
    chk("dsc_drain_rdy", b64.trn_tsrc_rdy_n, 1);
    chk("dsc_drain_lvl", lvl64, 5);
    chk("dsc_drop",      drop64, 1);
    chk("dsc_drain_td",  b64.trn_td, 0);
    step();
    step();
    chk("dsc_drain_rdy2", b64.trn_tsrc_rdy_n, 1);
    chk("dsc_drain_lvl2", lvl64, 3);
    step();
    chk("dsc_drain_lvl3", lvl64, 2);
    step();
    chk("dsc_b_b0_td",  b64.trn_td, 64'hBB00_0000_0000_0000);
    chk("dsc_b_b0_sof", b64.trn_tsof_n, 0);
    step();
    chk("dsc_b_b1_td",   b64.trn_td, 64'hBB00_0000_0000_0001);
    chk("dsc_b_b1_eof",  b64.trn_teof_n, 0);
    chk("dsc_b_b1_trem", b64.trn_trem_n, 8'h0F);
    step();
    chk("dsc_b_end_rdy", b64.trn_tsrc_rdy_n, 1);
    chk("dsc_b_end_lvl", lvl64, 0);
    chk("dsc_b_drop",    drop64, 1);

    // fill to full with core stalled, then drain in order
    b64.trn_tdst_rdy_n = 1;
    for (int i = 0; i < 20; i++) begin
      b64.s_valid = 1;
      b64.s_sof   = (i == 0);
      b64.s_eof   = (i == 15);
      b64.s_dw    = 1;
      b64.s_data  = 64'hC0DE_0000_0000_0000 | 64'(i);
      chk($sformatf("full_sready_%0d", i), b64.s_ready, (i < 16));
      step();
    end
    b64.s_valid = 0;
    chk("full_lvl",    lvl64, 16);
    chk("full_sready", b64.s_ready, 0);
    b64.trn_tdst_rdy_n = 0;
    for (int j = 0; j < 16; j++) begin
      chk($sformatf("full_td_%0d", j),   b64.trn_td, 64'hC0DE_0000_0000_0000 | 64'(j));
      chk($sformatf("full_sof_%0d", j),  b64.trn_tsof_n, (j != 0));
      chk($sformatf("full_eof_%0d", j),  b64.trn_teof_n, (j != 15));
      chk($sformatf("full_srdy_%0d", j), b64.s_ready, (j != 0));
      step();
    end
    chk("full_end_lvl", lvl64, 0);
    chk("full_end_rdy", b64.trn_tsrc_rdy_n, 1);

    // orphan beat
    put64(0, 1, 1, 64'hDEAD_0000_0000_0000);
    b64.s_valid = 0;
    chk("orph_lvl1", lvl64, 1);
    chk("orph_rdy1", b64.trn_tsrc_rdy_n, 1);
    step();
    chk("orph_lvl0", lvl64, 0);
    chk("orph_rdy0", b64.trn_tsrc_rdy_n, 1);
    chk("orph_drop", drop64, 2);

    // 128-bit: eof dw=2
    put128(1, 0, 2'd3, 128'hE000_0000_0000_0000_0000_0000_0000_0000);
    chk("w_lvl1", lvl128, 1);
    put128(0, 1, 2'd2, 128'hE000_0000_0000_0000_0000_0000_0000_0001);
    b128.s_valid = 0;
    chk("w_b0_td",   b128.trn_td, 128'hE000_0000_0000_0000_0000_0000_0000_0000);
    chk("w_b0_sof",  b128.trn_tsof_n, 0);
    chk("w_b0_trem", b128.trn_trem_n, 16'h0000);
    step();
    chk("w_b1_td",   b128.trn_td, 128'hE000_0000_0000_0000_0000_0000_0000_0001);
    chk("w_b1_eof",  b128.trn_teof_n, 0);
    chk("w_b1_trem", b128.trn_trem_n, 16'h000F);
    step();
    chk("w_end_rdy",  b128.trn_tsrc_rdy_n, 1);
    chk("w_end_trem", b128.trn_trem_n, 16'hFFFF);

    // 128-bit: link drop mid-packet
    put128(1, 0, 2'd3, 128'hF0);
    put128(0, 0, 2'd3, 128'hF1);
    put128(0, 1, 2'd3, 128'hF2);
    b128.s_valid = 0;
    chk("ld_b1_td", b128.trn_td, 128'hF1);
    chk("ld_lvl2",  lvl128, 2);
    b128.trn_lnk_up_n = 1;
    step();
    b128.trn_lnk_up_n = 0;
    chk("ld_drain_rdy", b128.trn_tsrc_rdy_n, 1);
    chk("ld_drop",      drop128, 1);
    chk("ld_drain_lvl", lvl128, 2);
    step();
    step();
    chk("ld_end_lvl", lvl128, 0);
    chk("ld_end_rdy", b128.trn_tsrc_rdy_n, 1);

    // 128-bit: asynchronous reset mid-packet
    put128(1, 0, 2'd3, 128'h1234);
    put128(0, 0, 2'd3, 128'h5678);
    b128.s_valid = 0;
    chk("ar_pre_rdy", b128.trn_tsrc_rdy_n, 0);
    #2 rst128 = 1'b1;
    #1;
    chk("ar_rdy",    b128.trn_tsrc_rdy_n, 1);
    chk("ar_sof",    b128.trn_tsof_n, 1);
    chk("ar_eof",    b128.trn_teof_n, 1);
    chk("ar_td",     b128.trn_td, 0);
    chk("ar_trem",   b128.trn_trem_n, 16'hFFFF);
    chk("ar_lvl",    lvl128, 0);
    chk("ar_drop",   drop128, 0);
    chk("ar_sready", b128.s_ready, 0);
    step();
    rst128 = 1'b0;
    step();
    chk("ar_post_rdy", b128.trn_tsrc_rdy_n, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
